// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - full-duplex SPI master, modes 0-3, 1..MAX_WIDTH bits, CS_NUM selects
module spi_master_multi #(
    parameter int MAX_WIDTH = 32,
    parameter int CS_NUM    = 4,
    parameter int CLK_DIV   = 2,
    parameter int LEN_W     = $clog2(MAX_WIDTH),
    parameter int SEL_W     = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic                 c_clk_100m,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    output logic                 o_ready,
    input  logic [MAX_WIDTH-1:0] i_tx_data,
    input  logic [LEN_W-1:0]     i_len,
    input  logic                 i_cpol,
    input  logic                 i_cpha,
    input  logic [SEL_W-1:0]     i_cs_sel,
    output logic                 o_done,
    output logic [MAX_WIDTH-1:0] o_rx_data,
    output logic                 o_spi_clk,
    output logic [CS_NUM-1:0]    o_spi_cs_n,
    output logic                 o_spi_mosi,
    input  logic                 i_spi_miso
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE,
        S_GAP
    } state_t;

    state_t               state_q;
    logic [DIV_W-1:0]     div_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     bit_q;
    logic                 cpol_q;
    logic                 cpha_q;
    logic [MAX_WIDTH-1:0] tx_q;
    logic [MAX_WIDTH-1:0] rx_q;
    logic [MAX_WIDTH-1:0] rx_data_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 sclk_q;
    logic                 mosi_q;
    logic [CS_NUM-1:0]    cs_n_q;
    logic [CS_NUM-1:0]    cs_n_d;
    logic                 tick_d;
    logic                 lead_d;
    logic                 sample_d;
    logic                 accept_d;

    // An out-of-range select matches no line, so the transfer runs with every CS high.
    always_comb begin
        cs_n_d = '1;
        for (int i = 0; i < CS_NUM; i++) begin
            if (i_cs_sel == SEL_W'(i)) cs_n_d[i] = 1'b0;
        end
    end

    assign tick_d   = (div_q == DIV_W'(CLK_DIV - 1));
    assign lead_d   = (sclk_q == cpol_q);
    assign sample_d = lead_d ^ cpha_q;
    assign accept_d = i_start & ready_q;

    always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            len_q     <= '0;
            bit_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
        end else begin
            done_q <= 1'b0;
            div_q  <= tick_d ? '0 : div_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    sclk_q <= i_cpol;
                    if (accept_d) begin
                        state_q <= S_SETUP;
                        ready_q <= 1'b0;
                        div_q   <= '0;
                        len_q   <= i_len;
                        cpol_q  <= i_cpol;
                        cpha_q  <= i_cpha;
                        bit_q   <= '0;
                        rx_q    <= '0;
                        cs_n_q  <= cs_n_d;
                        // CPHA=0 presents the MSB before the first edge; CPHA=1 shifts it out on that edge.
                        if (i_cpha) begin
                            tx_q   <= i_tx_data;
                            mosi_q <= 1'b0;
                        end else begin
                            tx_q   <= i_tx_data << 1;
                            mosi_q <= i_tx_data[i_len];
                        end
                    end
                end
                S_SETUP: begin
                    if (tick_d) state_q <= S_XFER;
                end
                S_XFER: begin
                    if (tick_d) begin
                        sclk_q <= ~sclk_q;
                        if (sample_d) begin
                            rx_q <= {rx_q[MAX_WIDTH-2:0], i_spi_miso};
                        end else begin
                            mosi_q <= tx_q[len_q];
                            tx_q   <= tx_q << 1;
                        end
                        if (!lead_d) begin
                            if (bit_q == len_q) state_q <= S_HOLD;
                            else                bit_q   <= bit_q + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (tick_d) state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q   <= S_GAP;
                    done_q    <= 1'b1;
                    rx_data_q <= rx_q;
                    mosi_q    <= 1'b0;
                    cs_n_q    <= '1;
                    div_q     <= '0;
                end
                S_GAP: begin
                    if (tick_d) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready    = ready_q;
    assign o_done     = done_q;
    assign o_rx_data  = rx_data_q;
    assign o_spi_clk  = sclk_q;
    assign o_spi_cs_n = cs_n_q;
    assign o_spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - randomized self-checking bench for spi_master_multi
module tb_spi_master_multi;
    localparam int MAX_WIDTH = 32;
    localparam int CS_NUM    = 5;
    localparam int CLK_DIV   = 2;
    localparam int LEN_W     = $clog2(MAX_WIDTH);
    localparam int SEL_W     = $clog2(CS_NUM);
    localparam int HALF      = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_start;
    logic                 o_ready;
    logic [MAX_WIDTH-1:0] i_tx_data;
    logic [LEN_W-1:0]     i_len;
    logic                 i_cpol;
    logic                 i_cpha;
    logic [SEL_W-1:0]     i_cs_sel;
    logic                 o_done;
    logic [MAX_WIDTH-1:0] o_rx_data;
    logic                 o_spi_clk;
    logic [CS_NUM-1:0]    o_spi_cs_n;
    logic                 o_spi_mosi;
    logic                 spi_miso;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    bit          cur_cpol, cur_cpha;
    int          cur_n, cur_sel, miso_mode;
    logic [63:0] cur_tx, slv_word, got_mosi;
    int          slv_idx;
    logic        slv_miso;
    bit          slv_active;
    int          n_edges, n_lead, bad_period, mosi_unstable;
    time         last_sclk_t, last_mosi_t;
    int          acc_cyc, done_cyc;
    bit          mid_tx_en;
    logic [63:0] mid_tx_val;

    always #HALF clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign spi_miso = (miso_mode == 1) ? o_spi_mosi : (miso_mode == 2) ? 1'b1 : slv_miso;

    spi_master_multi #(
        .MAX_WIDTH(MAX_WIDTH),
        .CS_NUM   (CS_NUM),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .c_clk_100m(clk),
        .i_rst_n   (rst_n),
        .i_start   (i_start),
        .o_ready   (o_ready),
        .i_tx_data (i_tx_data),
        .i_len     (i_len),
        .i_cpol    (i_cpol),
        .i_cpha    (i_cpha),
        .i_cs_sel  (i_cs_sel),
        .o_done    (o_done),
        .o_rx_data (o_rx_data),
        .o_spi_clk (o_spi_clk),
        .o_spi_cs_n(o_spi_cs_n),
        .o_spi_mosi(o_spi_mosi),
        .i_spi_miso(spi_miso)
    );

    // Slave: captures MOSI on its sampling edges, presents its word MSB first on the other edges.
    always @(o_spi_mosi) last_mosi_t = $time;

    always @(o_spi_clk) begin
        if (slv_active) begin
            if (n_edges > 0 && ($time - last_sclk_t) != time'(CLK_DIV * 2 * HALF)) bad_period++;
            last_sclk_t = $time;
            n_edges++;
            if (o_spi_clk != cur_cpol) n_lead++;
            if ((o_spi_clk != cur_cpol) ^ cur_cpha) begin
                got_mosi = {got_mosi[62:0], o_spi_mosi};
                if (last_mosi_t == $time) mosi_unstable++;
            end else begin
                slv_miso = (slv_idx >= 0) ? slv_word[slv_idx] : 1'b0;
                slv_idx--;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prep(input logic [63:0] tx, input int n, input bit cpol, input bit cpha,
                        input int sel, input int mmode, input logic [63:0] sword);
        cur_tx = tx; cur_n = n; cur_cpol = cpol; cur_cpha = cpha;
        cur_sel = sel; miso_mode = mmode; slv_word = sword;
        got_mosi = '0; n_edges = 0; n_lead = 0; bad_period = 0; mosi_unstable = 0;
        if (cpha) begin
            slv_idx  = n - 1;
            slv_miso = 1'b0;
        end else begin
            slv_miso = sword[n-1];
            slv_idx  = n - 2;
        end
        i_tx_data = tx[MAX_WIDTH-1:0];
        i_len     = LEN_W'(n - 1);
        i_cpol    = cpol;
        i_cpha    = cpha;
        i_cs_sel  = SEL_W'(sel);
        i_start   = 1'b1;
    endtask

    task automatic accept(input bit keep);
        int guard = 0;
        while (!o_ready && guard < 1000) begin
            step();
            guard++;
        end
        check_val("ready_wait", 64'(guard < 1000), 64'd1);
        step();
        acc_cyc    = cyc;
        slv_active = 1'b1;
        check_val("busy_after_accept", 64'(o_ready), 64'd0);
        check_val("sclk_idle_start", 64'(o_spi_clk), 64'(cur_cpol));
        if (!keep) i_start = 1'b0;
    endtask

    task automatic finish();
        int lat = 0;
        logic [CS_NUM-1:0] cs_mid = '1;
        logic [CS_NUM-1:0] exp_cs = '1;
        logic [63:0] mask, exp_rx;
        mask = (64'd1 << cur_n) - 64'd1;
        if (cur_sel < CS_NUM) exp_cs[cur_sel] = 1'b0;
        while (!o_done && lat < 5000) begin
            step();
            lat = cyc - acc_cyc;
            if (lat == 2 * CLK_DIV) cs_mid = o_spi_cs_n;
            if (mid_tx_en && lat == 3 * CLK_DIV) i_tx_data = mid_tx_val[MAX_WIDTH-1:0];
        end
        done_cyc   = cyc;
        slv_active = 1'b0;
        mid_tx_en  = 1'b0;
        if (miso_mode == 1)      exp_rx = cur_tx & mask;
        else if (miso_mode == 2) exp_rx = mask;
        else                     exp_rx = slv_word & mask;
        check_val("latency", 64'(lat), 64'(CLK_DIV * (2 * cur_n + 2) + 1));
        check_val("rx_data", 64'(o_rx_data), exp_rx);
        check_val("mosi_bits", got_mosi, cur_tx & mask);
        check_val("sclk_pulses", 64'(n_lead), 64'(cur_n));
        check_val("sclk_period", 64'(bad_period), 64'd0);
        check_val("mosi_stable", 64'(mosi_unstable), 64'd0);
        check_val("cs_during", 64'(cs_mid), 64'(exp_cs));
        check_val("cs_after", 64'(o_spi_cs_n), 64'((1 << CS_NUM) - 1));
        check_val("sclk_idle_end", 64'(o_spi_clk), 64'(cur_cpol));
        check_val("mosi_end", 64'(o_spi_mosi), 64'd0);
        step();
        check_val("done_pulse_width", 64'(o_done), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 64'(o_ready), 64'd1);
        check_val({tag, "_done"}, 64'(o_done), 64'd0);
        check_val({tag, "_rx"}, 64'(o_rx_data), 64'd0);
        check_val({tag, "_sclk"}, 64'(o_spi_clk), 64'd0);
        check_val({tag, "_cs"}, 64'(o_spi_cs_n), 64'((1 << CS_NUM) - 1));
        check_val({tag, "_mosi"}, 64'(o_spi_mosi), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; i_start = 1'b0; i_tx_data = '0; i_len = '0;
        i_cpol = 1'b0; i_cpha = 1'b0; i_cs_sel = '0;
        miso_mode = 0; slv_miso = 1'b0; slv_active = 1'b0; mid_tx_en = 1'b0;
        mid_tx_val = '0; last_sclk_t = 0; last_mosi_t = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        prep(64'hA5, 8, 1'b0, 1'b0, 0, 1, 64'h0);
        accept(1'b0); finish();

        prep(64'hDEADBEEF, 32, 1'b1, 1'b1, 1, 0, 64'h12345678);
        accept(1'b0); finish();

        prep(64'h1, 1, 1'b0, 1'b1, 2, 2, 64'h0);
        accept(1'b0); finish();
        prep(64'h1, 1, 1'b1, 1'b0, 3, 2, 64'h0);
        accept(1'b0); finish();

        prep(64'h3C, 8, 1'b0, 1'b0, 4, 1, 64'h0);
        accept(1'b1);
        mid_tx_en = 1'b1; mid_tx_val = 64'hC3;
        finish();
        prep(64'hC3, 8, 1'b0, 1'b0, 4, 1, 64'h0);
        accept(1'b0);
        check_val("reaccept_gap", 64'(acc_cyc - done_cyc), 64'(CLK_DIV + 1));
        finish();

        prep(64'h5A, 8, 1'b0, 1'b0, 5, 2, 64'h0);
        accept(1'b0); finish();

        prep(64'hCAFEF00D, 24, 1'b1, 1'b0, 2, 0, 64'h00ABCDEF);
        accept(1'b0);
        repeat (3 * CLK_DIV + 3) step();
        #2;
        slv_active = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        seen = 0;
        repeat (3) begin step(); if (o_done) seen++; end
        #2;
        rst_n = 1'b1;
        repeat (60) begin step(); if (o_done) seen++; end
        check_val("no_done_after_reset", 64'(seen), 64'd0);
        prep(64'h96, 8, 1'b1, 1'b1, 0, 0, 64'h69);
        accept(1'b0); finish();

        for (int t = 0; t < 25; t++) begin
            logic [63:0] tx, sw;
            tx = {$urandom, $urandom};
            sw = {$urandom, $urandom};
            prep(tx, $urandom_range(1, MAX_WIDTH), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7), $urandom_range(0, 2), sw);
            accept(1'b0);
            finish();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
